potential_bank_sequencer: RTL and testbench
===========================================

// Module: potential_bank_sequencer
// PURPOSE
//  Sequencing counterpart to the neuron potential window mux. Owns the membrane-potential store:
//  64 groups x 16 neurons x 8 bit. Per time step it sweeps all groups in two phases:
//  - store: drives cntrl_potential_out_sel and captures potential_out_16n into RAM.
//  - load: reads RAM back and drives potential_in_16n / cntrl_potential_in_sel into the array.
//  Sits between the global controller (start/done handshake) and the neuron selector.
// PARAMETERS
//  NUM_GROUPS  64   groups swept per phase
//  SEL_W       6    group select width, log2(NUM_GROUPS)
//  GROUP_W     128  bits per group (16 neurons x POT_W)
//  POT_W       8    potential width per neuron
// PORTS
//  clk                      in   1        rising-edge clock
//  rst_n                    in   1        async active-low reset
//  start_load               in   1        pulse: load RAM -> neuron array
//  start_store              in   1        pulse: store neuron array -> RAM
//  start_clear              in   1        pulse: zero all RAM groups
//  busy                     out  1        high while any phase runs
//  done                     out  1        1-cycle pulse when a phase completes
//  cntrl_potential_out_sel  out  SEL_W    group read from the array during store
//  potential_out_16n        in   GROUP_W  selected group potentials from the array
//  cntrl_potential_in_sel   out  SEL_W    group written into the array during load
//  potential_in_16n         out  GROUP_W  potentials for the selected group
//  potential_in_en          out  1        qualifies in_sel; top ANDs it into the array's in-enables
// BEHAVIOUR
//  - Reset: FSM IDLE; busy, done, potential_in_en = 0; both sels = 0; potential_in_16n = 0.
//    RAM contents are not reset.
//  - FSM states: IDLE, STORE, LOAD_PRE, LOAD, CLEAR, DONE. Group counter cnt is SEL_W bits.
//  - IDLE: sample the starts. If several are high at once, priority is clear > store > load.
//    Accepting any start sets cnt = 0 and busy = 1 on the next edge.
//  - Starts seen while busy are ignored and not queued.
//  - STORE: out_sel = cnt; RAM[cnt] <= potential_out_16n on the same edge (combinational path
//    through the mux). Lasts 64 cycles, cnt 0..63, then DONE.
//  - LOAD_PRE: one cycle issuing RAM read of address 0 (RAM has 1-cycle synchronous read).
//  - LOAD: each cycle potential_in_16n = RAM data for group cnt, in_sel = cnt, potential_in_en = 1,
//    read address = cnt+1. Lasts 64 cycles, then DONE.
//    Load phase total is 65 cycles from start to the last enable.
//  - CLEAR: RAM[cnt] <= 0 for cnt 0..63 (64 cycles), then DONE. No array-side outputs toggle.
//  - DONE: done = 1 for exactly one cycle, busy drops in the same cycle, then IDLE.
//  - cnt wraps 63 -> 0 only on a phase exit; the last group is always 63, never re-entered.
//  - potential_in_en is 0 outside LOAD. in_sel and potential_in_16n hold their last values
//    (no X driven).
//  - Reset asserted mid-phase: abort immediately, no done pulse.
//    RAM groups already written stay modified; remaining groups keep their old values.
//  - Widths: no arithmetic on potentials, bit-exact pass-through.
// STRUCTURE
//  - Shared package/header holds NUM_GROUPS, SEL_W, GROUP_W, POT_W, the FSM state encoding
//    and the phase command codes. The neuron selector and controller share the same constants.
//  - One sub-module: potential_ram, single-port 64 x 128, synchronous write, 1-cycle
//    synchronous read, write-first.
//  - The sequencer holds the FSM, the counter and the output registers.
// TESTING
//  1. Store/load round trip: array model returns {16{8'(g*3)}} for group g. start_store, wait
//     done, start_load -> for g = 0..63, in_en = 1 with in_sel = g and data {16{8'(g*3)}};
//     exactly 64 enables.
//  2. Latency: start_store at cycle 0 -> done at cycle 65. start_load at cycle 0 -> first in_en
//     at cycle 2, done at cycle 66. busy is high exactly between accept and done.
//  3. Clear: after test 1, start_clear then start_load -> every group delivers 128'h0.
//  4. Priority/ignore: start_store and start_load in the same cycle -> only store runs.
//     start_load pulsed mid-store -> ignored; a single done pulse is seen.
//  5. Reset mid-load: assert rst_n = 0 at group 20 -> in_en = 0 and sels = 0 immediately,
//     no done. A fresh start_load then replays all 64 groups with the stored data intact.
//  6. Enable hygiene: in IDLE for 100 cycles with random potential_out_16n -> potential_in_en
//     stays 0 and RAM is unchanged (verify by a later load).

Source files
------------

// File: rtl/potential_bank_sequencer_pkg.sv
// Shared constants, FSM encoding and phase command codes for the potential bank
// sequencer, neuron selector and global controller.
package potential_bank_sequencer_pkg;
  localparam int NUM_GROUPS = 64;
  localparam int SEL_W      = 6;
  localparam int POT_W      = 8;
  localparam int GROUP_W    = 16 * POT_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STORE,
    ST_LOAD_PRE,
    ST_LOAD,
    ST_CLEAR,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_LOAD,
    CMD_STORE,
    CMD_CLEAR
  } cmd_e;

  // Simultaneous requests resolve clear > store > load.
  function automatic cmd_e pick_cmd(input logic clr, input logic st, input logic ld);
    if (clr)     return CMD_CLEAR;
    else if (st) return CMD_STORE;
    else if (ld) return CMD_LOAD;
    else         return CMD_NONE;
  endfunction
endpackage

// File: rtl/potential_bank_sequencer_ram.sv
// Single-port 64 x 128 potential store: synchronous write, 1-cycle registered
// read, write-first. The read register holds its value when no read is issued.
module potential_ram
  import potential_bank_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_we,
  input  logic               i_re,
  input  logic [SEL_W-1:0]   i_addr,
  input  logic [GROUP_W-1:0] i_wdata,
  output logic [GROUP_W-1:0] o_rdata
);
  logic [GROUP_W-1:0] r_mem [NUM_GROUPS];
  logic [GROUP_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= i_we ? i_wdata : r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/potential_bank_sequencer.sv
// Sweeps all 64 neuron groups per phase: store (array -> RAM), load
// (RAM -> array) or clear (RAM -> 0), with a start/busy/done handshake.
module potential_bank_sequencer
  import potential_bank_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start_load,
  input  logic               i_start_store,
  input  logic               i_start_clear,
  output logic               o_busy,
  output logic               o_done,
  output logic [SEL_W-1:0]   o_cntrl_potential_out_sel,
  input  logic [GROUP_W-1:0] i_potential_out_16n,
  output logic [SEL_W-1:0]   o_cntrl_potential_in_sel,
  output logic [GROUP_W-1:0] o_potential_in_16n,
  output logic               o_potential_in_en
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_GROUPS - 1);
  localparam logic [SEL_W-1:0] ONE  = SEL_W'(1);

  state_e             r_state;
  logic [SEL_W-1:0]   r_cnt;
  logic [SEL_W-1:0]   r_out_sel;
  logic [SEL_W-1:0]   r_in_sel;
  logic               r_busy;
  logic               r_done;
  logic               r_in_en;
  logic               w_last;
  cmd_e               w_cmd;
  logic               w_ram_we;
  logic               w_ram_re;
  logic [SEL_W-1:0]   w_ram_addr;
  logic [GROUP_W-1:0] w_ram_wdata;
  logic [GROUP_W-1:0] w_ram_rdata;

  assign w_last = (r_cnt == LAST);
  assign w_cmd  = pick_cmd(i_start_clear, i_start_store, i_start_load);

  // Reads run one group ahead of the counter so the registered RAM output lines
  // up with in_sel in the same cycle.
  always_comb begin
    w_ram_we    = (r_state == ST_STORE) || (r_state == ST_CLEAR);
    w_ram_wdata = (r_state == ST_STORE) ? i_potential_out_16n : '0;
    w_ram_re    = (r_state == ST_LOAD_PRE) || ((r_state == ST_LOAD) && !w_last);
    w_ram_addr  = r_cnt;
    if (r_state == ST_LOAD_PRE) w_ram_addr = '0;
    else if (r_state == ST_LOAD) w_ram_addr = r_cnt + ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_out_sel <= '0;
      r_in_sel  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_in_en   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_cmd != CMD_NONE) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
          end
          case (w_cmd)
            CMD_CLEAR: r_state <= ST_CLEAR;
            CMD_STORE: begin
              r_state   <= ST_STORE;
              r_out_sel <= '0;
            end
            CMD_LOAD:  r_state <= ST_LOAD_PRE;
            default:   r_state <= ST_IDLE;
          endcase
        end
        ST_STORE, ST_CLEAR: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + ONE;
            if (r_state == ST_STORE) r_out_sel <= r_cnt + ONE;
          end
        end
        ST_LOAD_PRE: begin
          r_state  <= ST_LOAD;
          r_cnt    <= '0;
          r_in_sel <= '0;
          r_in_en  <= 1'b1;
        end
        ST_LOAD: begin
          if (w_last) begin
            r_state <= ST_DONE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_in_en <= 1'b0;
          end else begin
            r_cnt    <= r_cnt + ONE;
            r_in_sel <= r_cnt + ONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  potential_ram u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_ram_we),
    .i_re    (w_ram_re),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign o_busy                    = r_busy;
  assign o_done                    = r_done;
  assign o_cntrl_potential_out_sel = r_out_sel;
  assign o_cntrl_potential_in_sel  = r_in_sel;
  assign o_potential_in_en         = r_in_en;
  assign o_potential_in_16n        = w_ram_rdata;
endmodule

// File: tb/tb_potential_bank_sequencer.sv
// Randomised bench for potential_bank_sequencer: a neuron-array model feeds
// per-group data and a whole-store reference RAM predicts every load.
module tb_potential_bank_sequencer;
  import potential_bank_sequencer_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start_load = 1'b0, start_store = 1'b0, start_clear = 1'b0;
  logic               busy, done, in_en;
  logic [SEL_W-1:0]   out_sel, in_sel;
  logic [GROUP_W-1:0] in_16n;
  logic [GROUP_W-1:0] arr_data [NUM_GROUPS];
  logic [GROUP_W-1:0] ref_ram  [NUM_GROUPS];
  int                 n_tests = 0;
  int                 n_fail  = 0;

  always #5 clk = ~clk;

  potential_bank_sequencer dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .i_start_load              (start_load),
    .i_start_store             (start_store),
    .i_start_clear             (start_clear),
    .o_busy                    (busy),
    .o_done                    (done),
    .o_cntrl_potential_out_sel (out_sel),
    .i_potential_out_16n       (arr_data[out_sel]),
    .o_cntrl_potential_in_sel  (in_sel),
    .o_potential_in_16n        (in_16n),
    .o_potential_in_en         (in_en)
  );

  function automatic logic [GROUP_W-1:0] rand_group();
    logic [GROUP_W-1:0] v;
    for (int k = 0; k < GROUP_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Pulses the given starts ({clear,store,load}) in cycle 0 and observes the
  // phase until three cycles after the first done; optionally pulses
  // start_load again during cycle inj_cyc.
  task automatic run_phase(input logic [2:0] kind, input int inj_cyc,
                           output int done_cyc, output int n_done, output int n_en,
                           output int first_en, output int busy_bad,
                           output int data_bad, output int sel_bad);
    int post = 0;
    done_cyc = -1; n_done = 0; n_en = 0; first_en = -1;
    busy_bad = 0; data_bad = 0; sel_bad = 0;
    @(negedge clk);
    {start_clear, start_store, start_load} = kind;
    for (int cyc = 1; cyc <= 300 && post < 4; cyc++) begin
      @(negedge clk);
      {start_clear, start_store, start_load} = 3'b000;
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy !== (done_cyc < 0)) busy_bad++;
      if (kind == 3'b010 && cyc <= NUM_GROUPS && out_sel !== SEL_W'(cyc - 1)) sel_bad++;
      if (in_en === 1'b1) begin
        if (first_en < 0) first_en = cyc;
        if (n_en < NUM_GROUPS) begin
          if (in_sel !== SEL_W'(n_en)) sel_bad++;
          if (in_16n !== ref_ram[n_en]) data_bad++;
        end
        n_en++;
      end else if (in_en !== 1'b0) busy_bad++;
      if (done_cyc >= 0) post++;
      if (cyc == inj_cyc) start_load = 1'b1;
    end
    $display("[TB] phase %b: done@%0d dones=%0d enables=%0d first_en=%0d",
             kind, done_cyc, n_done, n_en, first_en);
  endtask

  // Full load whose data must match the reference RAM.
  task automatic verify_load(input string tag);
    int dc, nd, ne, fe, bb, db, sb;
    run_phase(3'b001, 0, dc, nd, ne, fe, bb, db, sb);
    n_tests++;
    if (ne !== NUM_GROUPS || db !== 0 || sb !== 0 || dc !== 66) begin
      $display("FAIL %s_load: enables=%0d data_err=%0d sel_err=%0d done@%0d, required 64/0/0/66",
               tag, ne, db, sb, dc);
      n_fail++;
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({busy, done, in_en} !== 3'b000) begin
      $display("FAIL reset_ctrl: busy/done/en=%b required 000", {busy, done, in_en});
      n_fail++;
    end
    n_tests++;
    if (in_sel !== '0 || out_sel !== '0) begin
      $display("FAIL reset_sel: in_sel=%0d out_sel=%0d required 0/0", in_sel, out_sel);
      n_fail++;
    end
    n_tests++;
    if (in_16n !== '0) begin
      $display("FAIL reset_data: in_16n=%h required 0", in_16n);
      n_fail++;
    end
  endtask

  task automatic test_roundtrip(input bit randomised);
    int dc, nd, ne, fe, bb, db, sb;
    for (int g = 0; g < NUM_GROUPS; g++)
      arr_data[g] = randomised ? rand_group() : {16{8'(g * 3)}};
    run_phase(3'b010, 0, dc, nd, ne, fe, bb, db, sb);
    for (int g = 0; g < NUM_GROUPS; g++) ref_ram[g] = arr_data[g];
    n_tests++;
    if (dc !== 65 || nd !== 1 || bb !== 0 || ne !== 0 || sb !== 0) begin
      $display("FAIL store_timing: done@%0d dones=%0d busy_err=%0d enables=%0d sel_err=%0d, required 65/1/0/0/0",
               dc, nd, bb, ne, sb);
      n_fail++;
    end
    run_phase(3'b001, 0, dc, nd, ne, fe, bb, db, sb);
    n_tests++;
    if (fe !== 2 || dc !== 66 || nd !== 1 || bb !== 0) begin
      $display("FAIL load_timing: first_en@%0d done@%0d dones=%0d busy_err=%0d, required 2/66/1/0",
               fe, dc, nd, bb);
      n_fail++;
    end
    n_tests++;
    if (ne !== NUM_GROUPS || db !== 0 || sb !== 0) begin
      $display("FAIL load_data: enables=%0d data_err=%0d sel_err=%0d, required 64/0/0", ne, db, sb);
      n_fail++;
    end
    n_tests++;
    if (in_en !== 1'b0 || in_sel !== SEL_W'(NUM_GROUPS - 1) || in_16n !== ref_ram[NUM_GROUPS-1]) begin
      $display("FAIL load_hold: en=%b sel=%0d data=%h, required 0/63/%h",
               in_en, in_sel, in_16n, ref_ram[NUM_GROUPS-1]);
      n_fail++;
    end
  endtask

  task automatic test_clear();
    int dc, nd, ne, fe, bb, db, sb;
    run_phase(3'b100, 0, dc, nd, ne, fe, bb, db, sb);
    for (int g = 0; g < NUM_GROUPS; g++) ref_ram[g] = '0;
    n_tests++;
    if (dc !== 65 || nd !== 1 || ne !== 0 || bb !== 0) begin
      $display("FAIL clear_timing: done@%0d dones=%0d enables=%0d busy_err=%0d, required 65/1/0/0",
               dc, nd, ne, bb);
      n_fail++;
    end
    verify_load("clear");
  endtask

  task automatic test_priority();
    int dc, nd, ne, fe, bb, db, sb;
    for (int g = 0; g < NUM_GROUPS; g++) arr_data[g] = rand_group();
    run_phase(3'b011, 0, dc, nd, ne, fe, bb, db, sb);
    for (int g = 0; g < NUM_GROUPS; g++) ref_ram[g] = arr_data[g];
    n_tests++;
    if (dc !== 65 || ne !== 0 || nd !== 1) begin
      $display("FAIL prio_store_over_load: done@%0d enables=%0d dones=%0d, required 65/0/1", dc, ne, nd);
      n_fail++;
    end
    verify_load("prio");
    for (int g = 0; g < NUM_GROUPS; g++) arr_data[g] = rand_group();
    run_phase(3'b010, 10, dc, nd, ne, fe, bb, db, sb);
    for (int g = 0; g < NUM_GROUPS; g++) ref_ram[g] = arr_data[g];
    n_tests++;
    if (nd !== 1 || ne !== 0 || dc !== 65 || bb !== 0) begin
      $display("FAIL ignore_mid_store: dones=%0d enables=%0d done@%0d busy_err=%0d, required 1/0/65/0",
               nd, ne, dc, bb);
      n_fail++;
    end
    verify_load("ignore");
  endtask

  task automatic test_reset_mid_load();
    int hit = 0, stray = 0;
    @(negedge clk);
    start_load = 1'b1;
    for (int cyc = 1; cyc <= 200 && hit == 0; cyc++) begin
      @(negedge clk);
      start_load = 1'b0;
      if (in_en === 1'b1 && in_sel === SEL_W'(20)) hit = 1;
    end
    n_tests++;
    if (hit == 0) begin
      $display("FAIL rst_load_reach: group 20 never enabled, required enabled");
      n_fail++;
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (in_en !== 1'b0 || in_sel !== '0 || out_sel !== '0 || busy !== 1'b0) begin
      $display("FAIL rst_load_abort: en=%b in_sel=%0d out_sel=%0d busy=%b, required 0/0/0/0",
               in_en, in_sel, out_sel, busy);
      n_fail++;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done !== 1'b0) stray++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done !== 1'b0) stray++;
    end
    n_tests++;
    if (stray !== 0) begin
      $display("FAIL rst_load_nodone: %0d done cycles, required 0", stray);
      n_fail++;
    end
    verify_load("rst_load");
  endtask

  // Reset during the sample of cycle 30: groups 0..28 were already written.
  task automatic test_reset_mid_store();
    for (int g = 0; g < NUM_GROUPS; g++) arr_data[g] = rand_group();
    @(negedge clk);
    start_store = 1'b1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk);
      start_store = 1'b0;
    end
    rst_n = 1'b0;
    for (int g = 0; g < 29; g++) ref_ram[g] = arr_data[g];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NUM_GROUPS; g++) arr_data[g] = rand_group();
    verify_load("rst_store");
  endtask

  task automatic test_idle_hygiene();
    int bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      arr_data[$urandom_range(0, NUM_GROUPS - 1)] = rand_group();
      if (in_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin
      $display("FAIL idle_quiet: %0d active cycles, required 0", bad);
      n_fail++;
    end
    verify_load("idle");
  endtask

  initial begin
    for (int g = 0; g < NUM_GROUPS; g++) arr_data[g] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_roundtrip(1'b0);
    test_clear();
    test_roundtrip(1'b1);
    test_priority();
    test_reset_mid_load();
    test_reset_mid_store();
    test_idle_hygiene();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
